// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fib_pkg
// Description : Shared types and constants for the Fibonacci pair serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package fib_pkg;

  // Default width of one data word.
  localparam int FIB_W = 16;

  // One buffered pair: a is the older word, b the newer.
  typedef struct packed {
    logic [FIB_W-1:0] a;
    logic [FIB_W-1:0] b;
  } fib_pair_t;

  // Which half of the head pair is currently presented on the output.
  typedef enum logic {
    HALF_A = 1'b0,
    HALF_B = 1'b1
  } half_e;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_pair_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fib_pair_fifo
// Description : Synchronous FIFO of word pairs with push/pop and full/empty.
//               Pushes while full and pops while empty are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_pair_fifo
  import fib_pkg::*;
#(
  parameter type T     = fib_pair_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           w_push;
  logic           w_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({w_push, w_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule : fib_pair_fifo
`default_nettype wire

// File: rtl/fib_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module      : fib_pair_serializer
// Description : Buffers incoming word pairs and emits them one word per
//               transfer (a then b), while checking that every emitted word
//               equals the wrapped sum of the two words emitted before it.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_pair_serializer
  import fib_pkg::*;
#(
  parameter int W     = FIB_W,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  input  logic         chk_clr,
  output logic         err_flag,
  output logic [7:0]   err_count
);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t        w_in_pair;
  pair_t        w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_out_xfer;
  logic         w_pop;
  logic [W-1:0] w_sum;

  half_e        half_q, half_d;

  logic [1:0]   seen_q, seen_d;
  logic [W-1:0] p1_q, p1_d;
  logic [W-1:0] p2_q, p2_d;
  logic         err_flag_q, err_flag_d;
  logic [7:0]   err_count_q, err_count_d;

  assign w_in_pair = '{a: in_a, b: in_b};

  fib_pair_fifo #(
    .T     (pair_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .din_i   (w_in_pair),
    .pop_i   (w_pop),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Handshake and data select come only from registered FIFO state and half.
  assign in_ready   = !w_full;
  assign out_valid  = !w_empty;
  assign out_data   = (half_q == HALF_B) ? w_head.b : w_head.a;
  assign w_out_xfer = out_valid && out_ready;
  assign w_pop      = w_out_xfer && (half_q == HALF_B);
  assign w_sum      = p1_q + p2_q;
  assign err_flag   = err_flag_q;
  assign err_count  = err_count_q;

  // Half-select state register.
  always_ff @(posedge clk) begin
    if (rst) half_q <= HALF_A;
    else     half_q <= half_d;
  end

  // Half-select next state: advance on every output transfer.
  always_comb begin
    half_d = half_q;
    if (w_out_xfer) begin
      case (half_q)
        HALF_A:  half_d = HALF_B;
        HALF_B:  half_d = HALF_A;
        default: half_d = HALF_A;
      endcase
    end
  end

  // Checker next state: clear wins, otherwise check and shift history on a transfer.
  always_comb begin
    seen_d      = seen_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (chk_clr) begin
      seen_d      = 2'd0;
      p1_d        = '0;
      p2_d        = '0;
      err_flag_d  = 1'b0;
      err_count_d = 8'd0;
    end else if (w_out_xfer) begin
      if ((seen_q == 2'd2) && (out_data != w_sum)) begin
        err_flag_d  = 1'b1;
        err_count_d = sat_inc8(err_count_q);
      end
      p2_d   = p1_q;
      p1_d   = out_data;
      seen_d = (seen_q == 2'd2) ? 2'd2 : seen_q + 2'd1;
    end
  end

  // Checker registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q      <= 2'd0;
      p1_q        <= '0;
      p2_q        <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      seen_q      <= seen_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

endmodule : fib_pair_serializer
`default_nettype wire

// File: tb/tb_fib_pair_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_pair_serializer
// Description : Self-checking bench for fib_pair_serializer. A word-queue
//               reference model predicts handshakes, output data and the
//               recurrence checker; directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_pair_serializer;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         chk_clr;
  logic         err_flag;
  logic [7:0]   err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending output words in emission order, plus checker history.
  logic [W-1:0] m_words [$];
  logic [W-1:0] m_hist  [$];
  logic         m_err;
  logic [7:0]   m_cnt;

  logic [W-1:0] g1, g2;

  fib_pair_serializer #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .chk_clr   (chk_clr),
    .err_flag  (err_flag),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
    return ((m_words.size() + 1) / 2) < DEPTH;
  endfunction

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic step(input logic r, input logic iv, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ordy, input logic clr);
    logic         e_rdy;
    logic         e_vld;
    logic [W-1:0] w;
    e_rdy = model_rdy();
    e_vld = (m_words.size() > 0);
    chk("in_ready",  32'(in_ready),  32'(e_rdy));
    chk("out_valid", 32'(out_valid), 32'(e_vld));
    if (e_vld) chk("out_data", 32'(out_data), 32'(m_words[0]));
    chk("err_flag",  32'(err_flag),  32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    rst       = r;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    chk_clr   = clr;
    @(posedge clk);
    if (r) begin
      m_words.delete();
      m_hist.delete();
      m_err = 1'b0;
      m_cnt = 8'd0;
    end else begin
      if (e_vld && ordy) begin
        w = m_words.pop_front();
        if (!clr) begin
          if (m_hist.size() == 2 && w != W'(m_hist[0] + m_hist[1])) begin
            m_err = 1'b1;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
          end
          m_hist.push_back(w);
          if (m_hist.size() > 2) void'(m_hist.pop_front());
        end
      end
      if (clr) begin
        m_hist.delete();
        m_err = 1'b0;
        m_cnt = 8'd0;
      end
      if (iv && e_rdy) begin
        m_words.push_back(a);
        m_words.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    m_err     = 1'b0;
    m_cnt     = 8'd0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    chk_clr   = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held for a second cycle, then the reset state is checked.
    step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Normal back-to-back stream.
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    chk("first_word_latency", 32'(out_valid), 32'd1);
    step(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd5, 16'd8, 1'b1, 1'b0);
    idle(7, 1'b1);
    chk("stream_err", 32'(err_flag), 32'd0);

    // Backpressure: five offers with the output stalled, then drain.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd13, 16'd21, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd34, 16'd55, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd89, 16'd144, 1'b0, 1'b0);
    step(1'b0, 1'b1, 16'd233, 16'd377, 1'b0, 1'b0);
    chk("bp_full", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 16'd610, 16'd987, 1'b0, 1'b0);
    chk("bp_hold_data", 32'(out_data), 32'd13);
    idle(10, 1'b1);

    // Recurrence violation, then clear.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd5, 16'd8, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd13, 16'd22, 1'b1, 1'b0);
    idle(8, 1'b1);
    chk("viol_flag",  32'(err_flag),  32'd1);
    chk("viol_count", 32'(err_count), 32'd1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    chk("clr_flag",  32'(err_flag),  32'd0);
    chk("clr_count", 32'(err_count), 32'd0);

    // Wrap-around sums are not errors.
    step(1'b0, 1'b1, 16'd28657, 16'd46368, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd9489, 16'd55857, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("overflow_flag", 32'(err_flag), 32'd0);

    // Reset while the head pair is half emitted.
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    step(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 1'b0);
    idle(6, 1'b1);
    chk("midrst_err", 32'(err_flag), 32'd0);

    // Randomized traffic: mostly valid recurrence data with occasional corruption.
    g1 = 16'd0;
    g2 = 16'd1;
    for (int i = 0; i < 3000; i++) begin
      logic         r, iv, ordy, clr;
      logic [W-1:0] a, b;
      r    = ($urandom_range(0, 299) == 0);
      clr  = ($urandom_range(0, 79) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      a    = g1 + g2;
      b    = g2 + a;
      if ($urandom_range(0, 15) == 0) b = W'($urandom);
      if ($urandom_range(0, 63) == 0) a = W'($urandom);
      if (iv && model_rdy() && !r) begin
        g1 = a;
        g2 = b;
      end
      step(r, iv, a, b, ordy, clr);
    end
    idle(10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fib_pair_serializer
`default_nettype wire
